spi_ram: RTL and testbench
==========================

Name: spi_ram

Overview:
- Downstream stage of the SPI slave. Consumes the 10-bit received words (rx_data/rx_valid) and decodes din[9:8] as a command.
- Holds a single-port synchronous memory plus separate write and read address registers.
- Returns read data to the slave on dout/tx_valid, which the slave serialises onto MISO.
- Detects out-of-order command sequences and flags them.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words. Must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width. Must be no greater than 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  10  word from the SPI slave: [9:8] command, [7:0] payload.
- rx_valid  input  1  din valid. The slave may hold it high for several cycles.
- dout  output  8  read data to the SPI slave.
- tx_valid  output  1  dout valid. Held high until the next accepted command.
- seq_err  output  1  one-cycle pulse on an illegal command sequence.

Behaviour:
- Clocking and reset:
  - All flops are on posedge clk with async clear on negedge rst_n.
  - Reset values: dout=0, tx_valid=0, seq_err=0, wr_addr=0, rd_addr=0, wr_addr_ok=0, rd_addr_ok=0, tx_state=TX_IDLE, rx_valid_q=0.
  - Memory contents are not reset.
- Command acceptance:
  - A command is accepted only on a rising edge of rx_valid (rx_valid & ~rx_valid_q).
  - Level-held rx_valid is accepted once. din is sampled in the accept cycle.
- Command decode on din[9:8]:
  - 00 WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0]; wr_addr_ok <= 1.
  - 01 WR_DATA:
    - If wr_addr_ok: mem[wr_addr] <= din[7:0], then wr_addr <= wr_addr+1. The address wraps MEM_DEPTH-1 -> 0.
    - Else: no write, and seq_err pulses.
  - 10 RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0]; rd_addr_ok <= 1.
  - 11 RD_DATA:
    - din[7:0] is a don't-care dummy.
    - If rd_addr_ok: start a fetch, then rd_addr_ok <= 0. One read per loaded read address.
    - Else: seq_err pulses, tx_valid stays 0, no fetch.
- Output FSM (tx_state):
  - TX_IDLE: tx_valid=0. Goes to TX_FETCH on an accepted legal RD_DATA.
  - TX_FETCH: one cycle of memory read latency. Goes to TX_HOLD, and dout <= mem[rd_addr] is registered on entry to TX_HOLD.
  - TX_HOLD: tx_valid=1 and dout is stable. Goes to TX_IDLE on the next accepted command of any type. tx_valid falls at the edge that accepts it.
  - Latency: accept edge of RD_DATA -> tx_valid high 2 clocks later.
  - A legal RD_DATA accepted while in TX_HOLD goes to TX_FETCH directly, with tx_valid low for the fetch cycle.
- Boundary conditions:
  - Write then read of the same address returns the new data. The write commits before the fetch cycle.
  - An RD_DATA accepted during TX_FETCH cannot occur, because an rx_valid edge needs at least one low cycle. The design may treat it as don't-care.
  - A second RD_DATA without a new RD_ADDR produces seq_err and no tx_valid.
  - WR_ADDR or RD_ADDR never disturbs the other address register or the other flag.
  - Reset mid-fetch or mid-hold clears tx_valid immediately (async) and discards the fetch.
  - seq_err is exactly one cycle wide, registered one cycle after the accept edge.

Decomposition:
- spi_ram_pkg:
  - cmd_e enum: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - tx_state_e enum: TX_IDLE, TX_FETCH, TX_HOLD.
  - Default localparams MEM_DEPTH and ADDR_SIZE.
- Sub-module spi_ram_array:
  - MEM_DEPTH x 8 storage, one write port, one synchronous read port, no reset.
  - The top level keeps edge detection, address registers, flags, the FSM and error logic.

Test Plan:
- Reset held 3 cycles, then released -> dout=0, tx_valid=0, seq_err=0. Any RD_DATA issued now -> seq_err pulse, tx_valid stays 0.
- Write sequence: din=0x0_05 (WR_ADDR 5), 0x1_A5, 0x1_3C. Then 0x2_05 and 0x3_00 -> tx_valid 2 cycles after accept, dout=0xA5. Then 0x2_06 and 0x3_00 -> dout=0x3C (auto-increment).
- WR_ADDR 0xFF, then WR_DATA 0x11 and 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22. Read both back to verify the wrap.
- rx_valid held high 10 cycles with din=0x1_77 after WR_ADDR 0x10 -> exactly one write. A read of 0x11 returns its old value, and a read of 0x10 returns 0x77.
- RD_ADDR 0x20, RD_DATA, RD_DATA -> first gives tx_valid with dout=mem[0x20]. Second gives seq_err for 1 cycle, and tx_valid drops at the second accept and stays 0.
- rst_n asserted during TX_FETCH -> tx_valid=0 and dout=0 asynchronously. After release, tx_state=TX_IDLE and both address flags are 0.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and default sizing for the spi_ram command decoder and its storage.
package spi_ram_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_FETCH,
    TX_HOLD
  } tx_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// MEM_DEPTH x 8 storage: one write port, one registered read port, contents not reset.
module spi_ram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [7:0]           i_wdata,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [7:0]           o_rdata
);

  logic [7:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/spi_ram.sv
// Command decoder for the SPI slave: address/data registers, sequence checking and
// the read-return FSM driving dout/tx_valid.
module spi_ram #(
  parameter int MEM_DEPTH = spi_ram_pkg::MEM_DEPTH,
  parameter int ADDR_SIZE = spi_ram_pkg::ADDR_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       seq_err
);

  import spi_ram_pkg::*;

  logic                 r_rx_valid_q;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wr_addr_ok;
  logic                 r_rd_addr_ok;
  logic [7:0]           r_dout;
  logic                 r_seq_err;
  tx_state_e            r_tx_state;
  tx_state_e            w_tx_next;

  logic                 w_accept;
  cmd_e                 w_cmd;
  logic                 w_we;
  logic                 w_rd_start;
  logic                 w_err;
  logic [7:0]           w_rdata;

  assign w_accept   = rx_valid & ~r_rx_valid_q;
  assign w_cmd      = cmd_e'(din[9:8]);
  assign w_we       = w_accept & (w_cmd == WR_DATA) & r_wr_addr_ok;
  assign w_rd_start = w_accept & (w_cmd == RD_DATA) & r_rd_addr_ok;
  assign w_err      = w_accept & (((w_cmd == WR_DATA) & ~r_wr_addr_ok) |
                                  ((w_cmd == RD_DATA) & ~r_rd_addr_ok));

  // The array reads rd_addr every cycle; the word sampled at the RD_DATA accept edge
  // is on o_rdata throughout TX_FETCH and is captured into dout on entry to TX_HOLD.
  spi_ram_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wr_addr),
    .i_wdata(din[7:0]),
    .i_raddr(r_rd_addr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_q <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wr_addr_ok <= 1'b0;
      r_rd_addr_ok <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_rx_valid_q <= rx_valid;
      r_seq_err    <= w_err;
      if (w_accept) begin
        unique case (w_cmd)
          WR_ADDR: begin
            r_wr_addr    <= din[ADDR_SIZE-1:0];
            r_wr_addr_ok <= 1'b1;
          end
          WR_DATA: begin
            if (r_wr_addr_ok) begin
              r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
            end
          end
          RD_ADDR: begin
            r_rd_addr    <= din[ADDR_SIZE-1:0];
            r_rd_addr_ok <= 1'b1;
          end
          RD_DATA: begin
            r_rd_addr_ok <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (w_rd_start) begin
          w_tx_next = TX_FETCH;
        end
      end
      TX_FETCH: begin
        w_tx_next = TX_HOLD;
      end
      TX_HOLD: begin
        if (w_rd_start) begin
          w_tx_next = TX_FETCH;
        end else if (w_accept) begin
          w_tx_next = TX_IDLE;
        end
      end
      default: begin
        w_tx_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (r_tx_state == TX_FETCH) begin
      r_dout <= w_rdata;
    end
  end

  assign dout     = r_dout;
  assign tx_valid = (r_tx_state == TX_HOLD);
  assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a command-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       seq_err;

  int total = 0;
  int bad   = 0;
  int seq_cycles = 0;
  bit chk_en = 0;

  spi_ram #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .rx_valid(rx_valid),
    .dout    (dout),
    .tx_valid(tx_valid),
    .seq_err (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory, address registers and flags as plain variables; the
  // read result becomes visible one edge after the RD_DATA accept edge.
  logic [7:0] m_mem [256];
  logic [7:0] m_wa, m_ra, m_pend;
  bit         m_wok, m_rok, m_prev, m_deliver;
  logic [7:0] e_dout;
  bit         e_valid, e_seq;

  initial begin
    bit acc;
    m_wa = '0; m_ra = '0; m_pend = '0; m_wok = 0; m_rok = 0; m_prev = 0;
    m_deliver = 0; e_dout = '0; e_valid = 0; e_seq = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_wa = '0; m_ra = '0; m_wok = 0; m_rok = 0; m_prev = 0;
        m_deliver = 0; e_dout = '0; e_valid = 0; e_seq = 0;
      end else begin
        acc    = rx_valid && !m_prev;
        m_prev = rx_valid;
        e_seq  = 0;
        if (m_deliver) begin
          e_valid   = 1;
          e_dout    = m_pend;
          m_deliver = 0;
        end
        if (acc) begin
          e_valid = 0;
          case (din[9:8])
            2'b00: begin m_wa = din[7:0]; m_wok = 1; end
            2'b01: begin
              if (m_wok) begin
                m_mem[m_wa] = din[7:0];
                m_wa = m_wa + 8'd1;
              end else begin
                e_seq = 1;
              end
            end
            2'b10: begin m_ra = din[7:0]; m_rok = 1; end
            default: begin
              if (m_rok) begin
                m_pend    = m_mem[m_ra];
                m_deliver = 1;
                m_rok     = 0;
              end else begin
                e_seq = 1;
              end
            end
          endcase
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (seq_err === 1'b1) seq_cycles++;
    if (chk_en) begin
      chk("cyc_tx_valid", {7'd0, tx_valid}, {7'd0, e_valid});
      chk("cyc_seq_err",  {7'd0, seq_err},  {7'd0, e_seq});
      chk("cyc_dout",     dout,             e_dout);
    end
  end

  // Entered and left at 1 time unit after a rising edge; leaves rx_valid low one cycle.
  task automatic send(input logic [9:0] w, input int hold = 1);
    din = w;
    rx_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
    send({2'b10, addr});
    send(10'h300);
    chk({name, "_valid"}, {7'd0, tx_valid}, 8'd1);
    chk({name, "_dout"}, dout, exp);
  endtask

  initial begin
    int s;
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 1'b0;
    din = '0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    chk("rst_seq_err", {7'd0, seq_err}, 8'd0);

    send(10'h300);
    chk("early_rd_seq_cycles", 8'(seq_cycles), 8'd1);
    chk("early_rd_no_valid", {7'd0, tx_valid}, 8'd0);

    send(10'h005);
    send(10'h1A5);
    send(10'h13C);
    rd(8'h05, 8'hA5, "rd05");
    rd(8'h06, 8'h3C, "rd06_autoinc");

    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    rd(8'hFF, 8'h11, "wrap_ff");
    rd(8'h00, 8'h22, "wrap_00");

    send(10'h011);
    send(10'h15A);
    send(10'h010);
    send(10'h177, 10);
    rd(8'h11, 8'h5A, "held_no_second_write");
    rd(8'h10, 8'h77, "held_single_write");

    send(10'h020);
    send(10'h1C3);
    rd(8'h20, 8'hC3, "rd20");
    s = seq_cycles;
    send(10'h300);
    chk("double_rd_seq", 8'(seq_cycles - s), 8'd1);
    chk("double_rd_no_valid", {7'd0, tx_valid}, 8'd0);
    chk("double_rd_dout_kept", dout, 8'hC3);

    rd(8'h05, 8'hA5, "pre_reset_rd");
    send(10'h220);
    din = 10'h300;
    rx_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    chk("async_rst_dout", dout, 8'h00);
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    s = seq_cycles;
    send(10'h300);
    send(10'h1EE);
    chk("post_rst_flags_clear", 8'(seq_cycles - s), 8'd2);
    chk("post_rst_dout", dout, 8'h00);

    repeat (2) @(posedge clk);
    #1 chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
